// File: rtl/req_arbiter8_pkg.sv
// Shared types and constants for the 8-requester arbiter.
// Package name arb_pkg; consumed by the interface, the encoder and the top.
package arb_pkg;
  localparam int N_REQ        = 8;
  localparam int IDX_W        = 3;
  localparam int DEF_MAX_HOLD = 16;
  localparam int HOLD_W       = 5;

  typedef enum logic {IDLE, GRANT} state_t;

  // Keeps only the bits strictly above ptr; ptr = 7 yields an empty mask
  // because 2 << 7 truncates to 0 in 8-bit arithmetic.
  function automatic logic [N_REQ-1:0] rr_mask(input logic [IDX_W-1:0] ptr);
    return ~((8'd2 << ptr) - 8'd1);
  endfunction
endpackage

// File: rtl/req_arbiter8_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface req_arbiter8_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             rr_en;
  logic [N_REQ-1:0] gnt;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_pos;
  logic             timeout;

  modport master (output req, rr_en, input gnt, gnt_valid, gnt_pos, timeout);
  modport slave  (input req, rr_en, output gnt, gnt_valid, gnt_pos, timeout);
endinterface

// File: rtl/req_arbiter8_prienc.sv
// Combinational 8->3 lowest-index-wins priority encoder with a found flag.
module arb_prienc8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);
  // Scanning from the top down lets the lowest set bit overwrite last.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = IDX_W'(i);
        found_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/req_arbiter8.sv
// Sequential 8-requester arbiter: fixed priority or round robin, grant held while requested.
// Optional hold timeout with per-requester re-arm mask is enabled by defining ARB_TIMEOUT_EN.
module req_arbiter8
  import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
  parameter int MAX_HOLD = DEF_MAX_HOLD
)
`endif
(
  input  logic           clk,
  input  logic           rst,
  req_arbiter8_if.slave  bus
);
  state_t           state_q;
  logic [N_REQ-1:0] gnt_q;
  logic             gnt_valid_q;
  logic [IDX_W-1:0] gnt_pos_q;
  logic [IDX_W-1:0] ptr_q;
  logic [N_REQ-1:0] req_eff;
  logic [IDX_W-1:0] idx_m, idx_u, winner;
  logic             found_m, found_u;

`ifdef ARB_TIMEOUT_EN
  logic [N_REQ-1:0]  block_q;
  logic [HOLD_W-1:0] hold_q;
  logic              timeout_q;
  // A force-released requester stays masked until it drops its request.
  assign req_eff = bus.req & ~block_q;
`else
  assign req_eff = bus.req;
`endif

  arb_prienc8 u_enc_masked (
    .vec_i   (req_eff & rr_mask(ptr_q)),
    .idx_o   (idx_m),
    .found_o (found_m)
  );

  arb_prienc8 u_enc_plain (
    .vec_i   (req_eff),
    .idx_o   (idx_u),
    .found_o (found_u)
  );

  assign winner = (bus.rr_en && found_m) ? idx_m : idx_u;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_pos_q   <= '0;
      ptr_q       <= IDX_W'(N_REQ - 1);
`ifdef ARB_TIMEOUT_EN
      block_q     <= '0;
      hold_q      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
      block_q   <= block_q & bus.req;
`endif
      case (state_q)
        IDLE: begin
          if (found_u) begin
            state_q     <= GRANT;
            gnt_q       <= N_REQ'(1) << winner;
            gnt_valid_q <= 1'b1;
            gnt_pos_q   <= winner;
            ptr_q       <= winner;
`ifdef ARB_TIMEOUT_EN
            hold_q      <= '0;
`endif
          end
        end
        GRANT: begin
          // Release always goes through IDLE, giving the one-cycle handoff bubble.
          if (!bus.req[gnt_pos_q]) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_pos_q   <= '0;
          end
`ifdef ARB_TIMEOUT_EN
          else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_pos_q   <= '0;
            timeout_q   <= 1'b1;
            block_q     <= (block_q & bus.req) | gnt_q;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_pos   = gnt_pos_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout   = timeout_q;
`else
  assign bus.timeout   = 1'b0;
`endif
endmodule

// File: tb/tb_req_arbiter8.sv
// Randomised and directed bench for req_arbiter8 against a cycle-level behavioural model.
module tb_req_arbiter8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int MAXH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  req_arbiter8_if bus();

  int total = 0;
  int bad   = 0;

  // Behavioural model state: who holds the grant, last winner, hold age, blocked requesters.
  bit       m_valid;
  int       m_pos;
  int       m_last;
  int       m_cnt;
  bit [7:0] m_block;
  bit       m_to;

`ifdef ARB_TIMEOUT_EN
  req_arbiter8 #(.MAX_HOLD(MAXH)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  req_arbiter8 dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  task automatic model_reset();
    m_valid = 1'b0;
    m_pos   = 0;
    m_last  = 7;
    m_cnt   = 0;
    m_block = 8'h00;
    m_to    = 1'b0;
  endtask

  task automatic model_step();
    bit [7:0] r;
    bit [7:0] eff;
    bit [7:0] force_bits;
    int       w;
    r          = bus.req;
    force_bits = 8'h00;
    m_to       = 1'b0;
    if (m_valid) begin
      if (!r[m_pos]) begin
        m_valid = 1'b0;
      end else if (TO_EN && m_cnt == MAXH - 1) begin
        m_valid           = 1'b0;
        m_to              = 1'b1;
        force_bits[m_pos] = 1'b1;
      end else begin
        m_cnt++;
      end
    end else begin
      eff = r & ~m_block;
      if (eff != 8'h00) begin
        w = -1;
        if (bus.rr_en) begin
          for (int k = 1; k <= 8; k++)
            if (w < 0 && eff[(m_last + k) % 8]) w = (m_last + k) % 8;
        end else begin
          for (int k = 0; k < 8; k++)
            if (w < 0 && eff[k]) w = k;
        end
        m_valid = 1'b1;
        m_pos   = w;
        m_last  = w;
        m_cnt   = 0;
      end
    end
    m_block = (m_block & r) | force_bits;
  endtask

  function automatic logic [12:0] exp_vec();
    logic [7:0] g;
    g = m_valid ? (8'd1 << m_pos) : 8'd0;
    return {g, m_valid, (m_valid ? 3'(m_pos) : 3'd0), m_to};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [12:0] act;
    model_reset();
    bus.req   = 8'h00;
    bus.rr_en = 1'b0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    act = {bus.gnt, bus.gnt_valid, bus.gnt_pos, bus.timeout};
    total++;
    if (act !== 13'd0) begin
      bad++;
      $display("FAIL reset_state: got %h want %h", act, 13'd0);
    end
    rst     = 1'b0;
    bus.req = 8'hFF;
    repeat (3) tick();
    // Async assertion mid-grant, checked before the next clock edge.
    @(posedge clk);
    model_step();
    #2 rst = 1'b1;
    #1 act = {bus.gnt, bus.gnt_valid, bus.gnt_pos, bus.timeout};
    total++;
    if (act !== 13'd0) begin
      bad++;
      $display("FAIL reset_async: got %h want %h", act, 13'd0);
    end
    model_reset();
    @(negedge clk);
    rst       = 1'b0;
    bus.rr_en = 1'b1;
    tick();
    total++;
    if (bus.gnt_valid !== 1'b1 || bus.gnt_pos !== 3'd0) begin
      bad++;
      $display("FAIL reset_first_grant: got valid=%b pos=%0d want valid=1 pos=0", bus.gnt_valid, bus.gnt_pos);
    end
    $display("reset: first grant pos=%0d", bus.gnt_pos);
  endtask

  task automatic test_fixed_priority();
    logic [12:0] act;
    bus.req = 8'h00;
    repeat (2) tick();
    bus.rr_en = 1'b0;
    bus.req   = 8'b1010_0100;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) bus.req[2] = 1'b0;
      tick();
      act = {bus.gnt, bus.gnt_valid, bus.gnt_pos, bus.timeout};
      total++;
      if (act !== exp_vec()) begin
        bad++;
        $display("FAIL fixed_cycle%0d: got %h want %h", c, act, exp_vec());
      end
      $display("fixed: cycle %0d gnt=%b pos=%0d", c, bus.gnt, bus.gnt_pos);
    end
    total++;
    if (bus.gnt !== 8'b0010_0000 || bus.gnt_pos !== 3'd5) begin
      bad++;
      $display("FAIL fixed_second: got gnt=%b pos=%0d want gnt=00100000 pos=5", bus.gnt, bus.gnt_pos);
    end
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst       = 1'b0;
    bus.rr_en = 1'b1;
    bus.req   = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      tick();
      total++;
      if (bus.gnt_valid !== 1'b1 || bus.gnt_pos !== 3'(g % 8) || bus.gnt !== (8'd1 << (g % 8))) begin
        bad++;
        $display("FAIL rr_grant%0d: got gnt=%b pos=%0d want pos=%0d", g, bus.gnt, bus.gnt_pos, g % 8);
      end
      tick();
      total++;
      if ({bus.gnt, bus.gnt_valid, bus.gnt_pos, bus.timeout} !== exp_vec()) begin
        bad++;
        $display("FAIL rr_hold%0d: got pos=%0d valid=%b want %h", g, bus.gnt_pos, bus.gnt_valid, exp_vec());
      end
      bus.req[g % 8] = 1'b0;
      tick();
      total++;
      if (bus.gnt_valid !== 1'b0 || bus.gnt !== 8'h00) begin
        bad++;
        $display("FAIL rr_bubble%0d: got valid=%b gnt=%b want valid=0 gnt=0", g, bus.gnt_valid, bus.gnt);
      end
      bus.req = 8'hFF;
      $display("rr: grant %0d pos=%0d", g, g % 8);
    end
  endtask

  task automatic test_wrap();
    bus.req = 8'h00;
    tick();
    bus.rr_en = 1'b1;
    bus.req   = 8'b0100_0000;
    tick();
    bus.req = 8'h00;
    tick();
    bus.req = 8'b0000_0011;
    tick();
    total++;
    if (bus.gnt_pos !== 3'd0 || bus.gnt_valid !== 1'b1 || m_pos != 0) begin
      bad++;
      $display("FAIL wrap_first: got pos=%0d valid=%b want pos=0 valid=1", bus.gnt_pos, bus.gnt_valid);
    end
    bus.req = 8'b0000_0010;
    tick();
    tick();
    total++;
    if (bus.gnt_pos !== 3'd1 || bus.gnt_valid !== 1'b1) begin
      bad++;
      $display("FAIL wrap_second: got pos=%0d valid=%b want pos=1 valid=1", bus.gnt_pos, bus.gnt_valid);
    end
    $display("wrap: second grant pos=%0d", bus.gnt_pos);
  endtask

  task automatic test_hold();
    logic [12:0] act;
    bus.req = 8'h00;
    repeat (2) tick();
    bus.req = 8'b0000_1000;
    tick();
    bus.req = 8'b0000_1001;
    for (int c = 0; c < 20; c++) begin
      tick();
      act = {bus.gnt, bus.gnt_valid, bus.gnt_pos, bus.timeout};
      total++;
      if (act !== exp_vec()) begin
        bad++;
        $display("FAIL hold_cycle%0d: got %h want %h", c, act, exp_vec());
      end
`ifndef ARB_TIMEOUT_EN
      total++;
      if (bus.gnt !== 8'b0000_1000 || bus.gnt_pos !== 3'd3) begin
        bad++;
        $display("FAIL hold_stable%0d: got gnt=%b pos=%0d want gnt=00001000 pos=3", c, bus.gnt, bus.gnt_pos);
      end
`endif
    end
    $display("hold: after 20 cycles gnt=%b pos=%0d", bus.gnt, bus.gnt_pos);
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    bus.req = 8'h00;
    repeat (2) tick();
    bus.req = 8'b0000_0010;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++;
      if (bus.gnt_valid !== 1'b1 || bus.gnt_pos !== 3'd1 || bus.timeout !== 1'b0) begin
        bad++;
        $display("FAIL timeout_held%0d: got valid=%b pos=%0d to=%b want 1/1/0", c, bus.gnt_valid, bus.gnt_pos, bus.timeout);
      end
    end
    tick();
    total++;
    if (bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b1) begin
      bad++;
      $display("FAIL timeout_release: got valid=%b to=%b want valid=0 to=1", bus.gnt_valid, bus.timeout);
    end
    repeat (3) tick();
    total++;
    if (bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b0) begin
      bad++;
      $display("FAIL timeout_blocked: got valid=%b to=%b want valid=0 to=0", bus.gnt_valid, bus.timeout);
    end
    bus.req = 8'h00;
    tick();
    bus.req = 8'b0000_0010;
    tick();
    total++;
    if (bus.gnt_valid !== 1'b1 || bus.gnt_pos !== 3'd1) begin
      bad++;
      $display("FAIL timeout_rearm: got valid=%b pos=%0d want valid=1 pos=1", bus.gnt_valid, bus.gnt_pos);
    end
    $display("timeout: re-armed grant pos=%0d", bus.gnt_pos);
  endtask
`endif

  task automatic test_random();
    logic [12:0] act;
    logic [7:0]  flip;
    int          errs_before;
    errs_before = bad;
    for (int c = 0; c < 400; c++) begin
      flip = 8'h00;
      for (int b = 0; b < 8; b++) flip[b] = ($urandom_range(0, 3) == 0);
      bus.req = bus.req ^ flip;
      if ($urandom_range(0, 15) == 0) bus.rr_en = ~bus.rr_en;
      tick();
      act = {bus.gnt, bus.gnt_valid, bus.gnt_pos, bus.timeout};
      total++;
      if (act !== exp_vec()) begin
        bad++;
        $display("FAIL random_cycle%0d: req=%b rr=%b got %h want %h", c, bus.req, bus.rr_en, act, exp_vec());
      end
    end
    $display("random: 400 cycles, %0d new errors", bad - errs_before);
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_wrap();
    test_hold();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
